// File: rtl/game_pkg.sv
// Shared game definitions: keycodes, facing and frog states, screen bounds,
// and a saturating score adder.
package game_pkg;

   localparam logic [15:0] KEY_W = 16'h001A;
   localparam logic [15:0] KEY_A = 16'h0004;
   localparam logic [15:0] KEY_S = 16'h0016;
   localparam logic [15:0] KEY_D = 16'h0007;

   // Indexed by facing value, so slot n is the key that turns the frog to dir n
   localparam logic [3:0][15:0] KEY_CODES = {KEY_D, KEY_S, KEY_A, KEY_W};

   typedef enum logic [1:0] {
      UP    = 2'd0,
      LEFT  = 2'd1,
      DOWN  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOP  = 2'd1,
      DEAD = 2'd2,
      OVER = 2'd3
   } frog_state_t;

   localparam int SCREEN_X_MIN  = 16;
   localparam int SCREEN_X_MAX  = 624;
   localparam int SCREEN_Y_GOAL = 32;
   localparam int SCREEN_Y_MAX  = 448;
   localparam int TILE_PX       = 32;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/key_edge_decode.sv
// Turns the raw keycode into a one-shot press strobe plus the facing it selects.
// A held key fires once; a different code or release-and-repress fires again.
module key_edge_decode
   import game_pkg::*;
(
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   output logic        new_press,
   output dir_t        key_dir
);

   logic [15:0] prev_key_reg;
   logic [3:0]  hit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit
         assign hit[gi] = (keycode == KEY_CODES[gi]);
      end
   endgenerate

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) prev_key_reg <= '0;
      else       prev_key_reg <= keycode;
   end

   assign new_press = (|hit) && (keycode != prev_key_reg);

   always_comb begin
      key_dir = UP;
      if (hit[1]) key_dir = LEFT;
      if (hit[2]) key_dir = DOWN;
      if (hit[3]) key_dir = RIGHT;
   end

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog motion controller: one tile hop per keypress, animated over HOP_FRAMES,
// plus death animation, respawn, lives, score and game-over sequencing.
module frog_hop_ctrl
   import game_pkg::*;
#(
   parameter int X_START      = 320,
   parameter int Y_START      = SCREEN_Y_MAX,
   parameter int X_MIN        = SCREEN_X_MIN,
   parameter int X_MAX        = SCREEN_X_MAX,
   parameter int Y_GOAL       = SCREEN_Y_GOAL,
   parameter int Y_MAX        = SCREEN_Y_MAX,
   parameter int TILE         = TILE_PX,
   parameter int HOP_FRAMES   = 8,
   parameter int DEATH_FRAMES = 60,
   parameter int LIVES_INIT   = 3,
   parameter int FROG_SIZE    = 12
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   input  logic        collision,
   output logic [9:0]  FrogX,
   output logic [9:0]  FrogY,
   output logic [9:0]  FrogS,
   output logic [1:0]  dir,
   output logic        hopping,
   output logic        dead,
   output logic [1:0]  lives,
   output logic [7:0]  score,
   output logic        game_over
);

   generate
      if ((TILE % HOP_FRAMES) != 0) begin : g_bad_hop_frames
         $error("TILE must be an integer multiple of HOP_FRAMES");
      end
   endgenerate

   localparam int HCW = $clog2(HOP_FRAMES + 1);
   localparam int DCW = $clog2(DEATH_FRAMES + 1);

   localparam logic [9:0]     STEP_PX    = 10'(TILE / HOP_FRAMES);
   localparam logic [9:0]     TILE10     = 10'(TILE);
   localparam logic [9:0]     X_START10  = 10'(X_START);
   localparam logic [9:0]     Y_START10  = 10'(Y_START);
   localparam logic [9:0]     X_MAX10    = 10'(X_MAX);
   localparam logic [9:0]     Y_MAX10    = 10'(Y_MAX);
   localparam logic [9:0]     Y_GOAL10   = 10'(Y_GOAL);
   localparam logic [9:0]     UP_MIN     = 10'(Y_GOAL + TILE);
   localparam logic [9:0]     LEFT_MIN   = 10'(X_MIN + TILE);
   localparam logic [HCW-1:0] HOP_LAST   = HCW'(HOP_FRAMES - 1);
   localparam logic [DCW-1:0] DEATH_LAST = DCW'(DEATH_FRAMES - 1);
   localparam logic [1:0]     LIVES_RST  = 2'(LIVES_INIT);

   frog_state_t    state_reg, state_next;
   dir_t           dir_reg, dir_next;
   logic [9:0]     x_reg, x_next, y_reg, y_next, best_y_reg, best_y_next;
   logic [1:0]     lives_reg, lives_next;
   logic [7:0]     score_reg, score_next;
   logic [HCW-1:0] hop_cnt_reg, hop_cnt_next;
   logic [DCW-1:0] death_cnt_reg, death_cnt_next;

   logic       new_press;
   dir_t       key_dir;
   logic       dest_legal;
   logic [9:0] x_step, y_step;

   key_edge_decode u_key_edge_decode (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .new_press (new_press),
      .key_dir   (key_dir)
   );

   // Bounds are compared in forms that never subtract below zero
   always_comb begin
      case (key_dir)
         UP:      dest_legal = (y_reg >= UP_MIN);
         DOWN:    dest_legal = ((y_reg + TILE10) <= Y_MAX10);
         LEFT:    dest_legal = (x_reg >= LEFT_MIN);
         RIGHT:   dest_legal = ((x_reg + TILE10) <= X_MAX10);
         default: dest_legal = 1'b0;
      endcase
   end

   always_comb begin
      x_step = x_reg;
      y_step = y_reg;
      case (dir_reg)
         UP:      y_step = y_reg - STEP_PX;
         DOWN:    y_step = y_reg + STEP_PX;
         LEFT:    x_step = x_reg - STEP_PX;
         RIGHT:   x_step = x_reg + STEP_PX;
         default: ;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      dir_next       = dir_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      best_y_next    = best_y_reg;
      lives_next     = lives_reg;
      score_next     = score_reg;
      hop_cnt_next   = hop_cnt_reg;
      death_cnt_next = death_cnt_reg;

      case (state_reg)
         IDLE, HOP: begin
            if (collision) begin
               state_next     = DEAD;
               death_cnt_next = '0;
               lives_next     = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
            end else if (state_reg == IDLE) begin
               if (new_press) begin
                  dir_next = key_dir;
                  if (dest_legal) begin
                     state_next   = HOP;
                     hop_cnt_next = '0;
                  end
               end
            end else begin
               x_next       = x_step;
               y_next       = y_step;
               hop_cnt_next = hop_cnt_reg + 1'b1;
               if (hop_cnt_reg == HOP_LAST) begin
                  state_next = IDLE;
                  // Reaching the goal banks the bonus and sends the frog home at once
                  if (y_step == Y_GOAL10) begin
                     score_next  = sat_add8(score_reg, 8'd10);
                     x_next      = X_START10;
                     y_next      = Y_START10;
                     best_y_next = Y_START10;
                  end else if (y_step < best_y_reg) begin
                     score_next  = sat_add8(score_reg, 8'd1);
                     best_y_next = y_step;
                  end
               end
            end
         end
         DEAD: begin
            if (death_cnt_reg == DEATH_LAST) begin
               if (lives_reg == 2'd0) begin
                  state_next = OVER;
               end else begin
                  state_next  = IDLE;
                  x_next      = X_START10;
                  y_next      = Y_START10;
                  dir_next    = UP;
                  best_y_next = Y_START10;
               end
            end else begin
               death_cnt_next = death_cnt_reg + 1'b1;
            end
         end
         OVER:    ;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= IDLE;
         dir_reg       <= UP;
         x_reg         <= X_START10;
         y_reg         <= Y_START10;
         best_y_reg    <= Y_START10;
         lives_reg     <= LIVES_RST;
         score_reg     <= '0;
         hop_cnt_reg   <= '0;
         death_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         dir_reg       <= dir_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         best_y_reg    <= best_y_next;
         lives_reg     <= lives_next;
         score_reg     <= score_next;
         hop_cnt_reg   <= hop_cnt_next;
         death_cnt_reg <= death_cnt_next;
      end
   end

   assign FrogX     = x_reg;
   assign FrogY     = y_reg;
   assign FrogS     = 10'(FROG_SIZE);
   assign dir       = dir_reg;
   assign hopping   = (state_reg == HOP);
   assign dead      = (state_reg == DEAD);
   assign lives     = lives_reg;
   assign score     = score_reg;
   assign game_over = (state_reg == OVER);

endmodule
